// File: rtl/flash_arbiter.sv
// flash_arbiter: two-port read arbiter sharing a single flash read port
// Ports: m0_* audio reader and m1_* auxiliary requester (read-only, pipelined valid),
//        flsh_* flash master side, busy/grant_id/err_timeout status.
module flash_arbiter #(
  parameter int ADDR_W     = 23,
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic [3:0]        m0_byteenable,
  output logic              m0_waitrequest,
  output logic [31:0]       m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic [3:0]        m1_byteenable,
  output logic              m1_waitrequest,
  output logic [31:0]       m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] flsh_address,
  output logic              flsh_read,
  output logic [3:0]        flsh_byteenable,
  input  logic              flsh_waitrequest,
  input  logic [31:0]       flsh_readdata,
  input  logic              flsh_readdatavalid,
  output logic              busy,
  output logic              grant_id,
  output logic              err_timeout
);
  localparam int SW = $clog2(MAX_STREAK + 2);
  localparam int CW = $clog2(TIMEOUT + 2);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA} state_t;
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be;
  logic              r_gid, r_rdv0, r_rdv1, r_err;
  logic [31:0]       r_rd0, r_rd1;
  logic [SW-1:0]     r_streak;
  logic [CW-1:0]     r_cnt;
  logic              w_idle, w_g0, w_g1, w_dv, w_to, w_done;
  logic [31:0]       w_rdata;
  always_comb begin
    w_idle = r_state == IDLE;
    // port 1 wins when port 0 is quiet or has used up its streak allowance
    w_g1 = w_idle && m1_read && (!m0_read || r_streak == SW'(MAX_STREAK));
    w_g0 = w_idle && m0_read && !w_g1;
    w_dv = r_state == WAIT_DATA && flsh_readdatavalid;
    // data arriving on the expiry cycle suppresses the timeout
    w_to = r_state == WAIT_DATA && !flsh_readdatavalid && r_cnt == CW'(TIMEOUT);
    w_done = w_dv || w_to;
    w_rdata = w_dv ? flsh_readdata : 32'h0;
    w_next = (w_g0 || w_g1) ? ISSUE :
             (r_state == ISSUE && !flsh_waitrequest) ? WAIT_DATA :
             w_done ? IDLE : r_state;
    // gated by rst_n so both ports stall while reset is held
    m0_waitrequest = !(rst_n && w_g0);
    m1_waitrequest = !(rst_n && w_g1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_be     <= '0;
      r_gid    <= 1'b0;
      r_streak <= '0;
      r_cnt    <= '0;
      r_rd0    <= '0;
      r_rd1    <= '0;
      r_rdv0   <= 1'b0;
      r_rdv1   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_g0 || w_g1) begin
        r_addr   <= w_g1 ? m1_address : m0_address;
        r_be     <= w_g1 ? m1_byteenable : m0_byteenable;
        r_gid    <= w_g1;
        r_streak <= !(w_g0 && m1_read) ? '0 :
                    r_streak == SW'(MAX_STREAK) ? r_streak : r_streak + SW'(1);
      end
      r_cnt  <= r_state == WAIT_DATA ? r_cnt + CW'(1) : '0;
      r_rdv0 <= w_done && !r_gid;
      r_rdv1 <= w_done && r_gid;
      if (w_done && !r_gid) r_rd0 <= w_rdata;
      if (w_done && r_gid) r_rd1 <= w_rdata;
      r_err <= w_to;
    end
  end
  assign flsh_read        = r_state == ISSUE;
  assign flsh_address     = r_addr;
  assign flsh_byteenable  = r_be;
  assign busy             = !w_idle;
  assign grant_id         = r_gid;
  assign err_timeout      = r_err;
  assign m0_readdata      = r_rd0;
  assign m1_readdata      = r_rd1;
  assign m0_readdatavalid = r_rdv0;
  assign m1_readdatavalid = r_rdv1;
endmodule

// File: tb/tb_flash_arbiter.sv
// tb_flash_arbiter: scoreboard bench for flash_arbiter
module tb_flash_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [22:0] m0_address = '0, m1_address = '0, flsh_address;
  logic        m0_read = 1'b0, m1_read = 1'b0;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0, flsh_byteenable;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata, flsh_readdata = '0;
  logic        flsh_read, flsh_waitrequest = 1'b0, flsh_readdatavalid = 1'b0;
  logic        busy, grant_id, err_timeout;
  typedef struct {bit p; logic [31:0] d; bit e;} exp_t;
  exp_t        sb[$];
  int          n_cmp = 0, n_bad = 0;
  logic [31:0] last_rd [2];
  always #5 clk = ~clk;
  flash_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .flsh_address(flsh_address), .flsh_read(flsh_read), .flsh_byteenable(flsh_byteenable),
    .flsh_waitrequest(flsh_waitrequest), .flsh_readdata(flsh_readdata),
    .flsh_readdatavalid(flsh_readdatavalid),
    .busy(busy), .grant_id(grant_id), .err_timeout(err_timeout)
  );
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      last_rd[0] = '0;
      last_rd[1] = '0;
    end else if (m0_readdatavalid || m1_readdatavalid || err_timeout) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_rdv: m0v=%b m1v=%b err=%b, required no response", m0_readdatavalid, m1_readdatavalid, err_timeout);
      end else begin
        e = sb.pop_front();
        n_cmp++;
        if ({m1_readdatavalid, m0_readdatavalid} !== (e.p ? 2'b10 : 2'b01)) begin
          n_bad++;
          $display("FAIL rdv_port: got {m1v,m0v}=%b, required port %0d only", {m1_readdatavalid, m0_readdatavalid}, e.p);
        end
        n_cmp++;
        if ((e.p ? m1_readdata : m0_readdata) !== e.d) begin
          n_bad++;
          $display("FAIL readdata: port %0d got %h, required %h", e.p, e.p ? m1_readdata : m0_readdata, e.d);
        end
        n_cmp++;
        if ((e.p ? m0_readdata : m1_readdata) !== last_rd[!e.p]) begin
          n_bad++;
          $display("FAIL other_port_data: port %0d got %h, required %h", !e.p, e.p ? m0_readdata : m1_readdata, last_rd[!e.p]);
        end
        n_cmp++;
        if (err_timeout !== e.e) begin
          n_bad++;
          $display("FAIL err_timeout: got %b, required %b", err_timeout, e.e);
        end
        last_rd[e.p] = e.d;
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic run_xact(input bit p, input logic [22:0] a, input logic [3:0] be, input int ws,
                          input int lat, input logic [31:0] d, input bit spur, output int waited);
    exp_t e;
    waited = 0;
    if (p) begin m1_read = 1; m1_address = a; m1_byteenable = be; end
    else begin m0_read = 1; m0_address = a; m0_byteenable = be; end
    #1;
    while ((p ? m1_waitrequest : m0_waitrequest) && waited < 50) begin cyc(); #1; waited++; end
    n_cmp++;
    if (waited >= 50) begin
      n_bad++;
      $display("FAIL accept: port %0d waitrequest still 1 after %0d cycles, required 0", p, waited);
      m0_read = 0; m1_read = 0;
      return;
    end
    e.p = p; e.d = lat < 0 ? 32'h0 : d; e.e = lat < 0;
    sb.push_back(e);
    cyc();
    m0_read = 0; m1_read = 0;
    n_cmp++;
    if ({flsh_read, flsh_address, flsh_byteenable, grant_id, busy, m0_waitrequest, m1_waitrequest} !== {1'b1, a, be, p, 1'b1, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL issue: got rd=%b addr=%h be=%h gid=%b busy=%b wr=%b%b, required 1 %h %h %b 1 11",
               flsh_read, flsh_address, flsh_byteenable, grant_id, busy, m0_waitrequest, m1_waitrequest, a, be, p);
    end
    flsh_readdata = 32'hBAD0BAD0;
    for (int i = 0; i < ws; i++) begin flsh_waitrequest = 1; flsh_readdatavalid = spur; cyc(); end
    flsh_waitrequest = 0; flsh_readdatavalid = spur;
    cyc();
    flsh_readdatavalid = 0;
    n_cmp++;
    if ({flsh_read, flsh_address, busy, m0_readdatavalid, m1_readdatavalid} !== {1'b0, a, 1'b1, 2'b00}) begin
      n_bad++;
      $display("FAIL wait_entry: got rd=%b addr=%h busy=%b rdv=%b%b, required 0 %h 1 00",
               flsh_read, flsh_address, busy, m0_readdatavalid, m1_readdatavalid, a);
    end
    if (lat < 0) return;
    for (int i = 0; i < lat; i++) cyc();
    flsh_readdatavalid = 1; flsh_readdata = d;
    cyc();
    flsh_readdatavalid = 0;
    n_cmp++;
    if ({(p ? m1_readdatavalid : m0_readdatavalid), busy, err_timeout} !== 3'b100) begin
      n_bad++;
      $display("FAIL data_return: got rdv=%b busy=%b err=%b, required 1 0 0",
               p ? m1_readdatavalid : m0_readdatavalid, busy, err_timeout);
    end
  endtask
  task automatic test_reset();
    m0_read = 1; m1_read = 1;
    #3;
    n_cmp++;
    if ({m0_waitrequest, m1_waitrequest, flsh_read, flsh_address, flsh_byteenable, busy, grant_id, err_timeout} !== {2'b11, 1'b0, 23'h0, 4'h0, 3'b000}) begin
      n_bad++;
      $display("FAIL reset_ctrl: got wr=%b%b rd=%b addr=%h be=%h busy=%b gid=%b err=%b, required 11 0 0 0 0 0 0",
               m0_waitrequest, m1_waitrequest, flsh_read, flsh_address, flsh_byteenable, busy, grant_id, err_timeout);
    end
    n_cmp++;
    if ({m0_readdata, m1_readdata, m0_readdatavalid, m1_readdatavalid} !== 66'h0) begin
      n_bad++;
      $display("FAIL reset_data: got %h %h %b %b, required zeros", m0_readdata, m1_readdata, m0_readdatavalid, m1_readdatavalid);
    end
    cyc(); cyc();
    m0_read = 0; m1_read = 0; rst_n = 1;
    cyc();
  endtask
  task automatic test_single_read();
    int w;
    run_xact(0, 23'h000010, 4'hF, 2, 3, 32'hDEADBEEF, 0, w);
  endtask
  task automatic test_back_to_back();
    int w;
    run_xact(1, 23'h000100, 4'h3, 0, 0, 32'hA5A55A5A, 0, w);
    run_xact(0, 23'h7FFFFF, 4'hC, 0, 0, 32'h01020304, 0, w);
    n_cmp++;
    if (w !== 0) begin n_bad++; $display("FAIL back_to_back: accept waited %0d cycles, required 0", w); end
    run_xact(1, 23'h0ABCDE, 4'h1, 1, 2, 32'hCAFEF00D, 1, w);
    n_cmp++;
    if (w !== 0) begin n_bad++; $display("FAIL back_to_back2: accept waited %0d cycles, required 0", w); end
  endtask
  task automatic test_contention();
    bit exp_g [10];
    int n;
    exp_t e;
    exp_g = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    m0_address = 23'h000040; m1_address = 23'h000080; m0_byteenable = 4'hF; m1_byteenable = 4'hF;
    m0_read = 1; m1_read = 1;
    for (int k = 0; k < 10; k++) begin
      n = 0;
      #1;
      while (m0_waitrequest && m1_waitrequest && n < 20) begin cyc(); #1; n++; end
      n_cmp++;
      if ({m1_waitrequest, m0_waitrequest} !== (exp_g[k] ? 2'b01 : 2'b10)) begin
        n_bad++;
        $display("FAIL contention_grant[%0d]: got {m1wr,m0wr}=%b, required grant to port %0d", k, {m1_waitrequest, m0_waitrequest}, exp_g[k]);
      end
      e.p = exp_g[k]; e.d = 32'hC0DE0000 + 32'(k); e.e = 0;
      sb.push_back(e);
      cyc();
      n_cmp++;
      if (grant_id !== exp_g[k]) begin
        n_bad++;
        $display("FAIL contention_gid[%0d]: got %b, required %b", k, grant_id, exp_g[k]);
      end
      cyc();
      flsh_readdatavalid = 1; flsh_readdata = e.d;
      cyc();
      flsh_readdatavalid = 0;
    end
    m0_read = 0; m1_read = 0;
    cyc(); cyc();
  endtask
  task automatic test_timeout();
    int w;
    run_xact(0, 23'h000020, 4'hF, 0, -1, 32'h0, 0, w);
    for (int i = 0; i < 255; i++) cyc();
    n_cmp++;
    if ({m0_readdatavalid, err_timeout, busy} !== 3'b001) begin
      n_bad++;
      $display("FAIL timeout_early: at count 255 got rdv=%b err=%b busy=%b, required 0 0 1", m0_readdatavalid, err_timeout, busy);
    end
    cyc();
    n_cmp++;
    if ({m0_readdatavalid, err_timeout, busy, m0_readdata} !== {3'b110, 32'h0}) begin
      n_bad++;
      $display("FAIL timeout_fire: got rdv=%b err=%b busy=%b data=%h, required 1 1 0 0", m0_readdatavalid, err_timeout, busy, m0_readdata);
    end
    cyc();
    n_cmp++;
    if ({m0_readdatavalid, err_timeout} !== 2'b00) begin
      n_bad++;
      $display("FAIL timeout_pulse: got rdv=%b err=%b, required 0 0", m0_readdatavalid, err_timeout);
    end
  endtask
  task automatic test_coincidence();
    int w;
    run_xact(1, 23'h000333, 4'h6, 1, 255, 32'h12345678, 0, w);
    n_cmp++;
    if ({m1_readdata, err_timeout} !== {32'h12345678, 1'b0}) begin
      n_bad++;
      $display("FAIL coincidence: got data=%h err=%b, required 12345678 0", m1_readdata, err_timeout);
    end
    cyc();
  endtask
  task automatic test_spurious();
    flsh_readdatavalid = 1; flsh_readdata = 32'hBAADF00D;
    cyc();
    flsh_readdatavalid = 0;
    cyc();
    n_cmp++;
    if ({m0_readdatavalid, m1_readdatavalid, busy, flsh_read, m0_readdata, m1_readdata} !== {4'b0000, last_rd[0], last_rd[1]}) begin
      n_bad++;
      $display("FAIL spurious: got rdv=%b%b busy=%b rd=%b data=%h/%h, required 0 0 0 0 %h/%h",
               m0_readdatavalid, m1_readdatavalid, busy, flsh_read, m0_readdata, m1_readdata, last_rd[0], last_rd[1]);
    end
  endtask
  task automatic test_reset_mid();
    m1_read = 1; m1_address = 23'h055555; m1_byteenable = 4'hF;
    #1;
    n_cmp++;
    if (m1_waitrequest !== 1'b0) begin n_bad++; $display("FAIL reset_mid_accept: got m1wr=%b, required 0", m1_waitrequest); end
    cyc();
    m1_read = 0; flsh_waitrequest = 0;
    cyc(); cyc(); cyc();
    #2;
    rst_n = 0; m0_read = 1; m1_read = 1;
    #1;
    n_cmp++;
    if ({busy, flsh_read, flsh_address, m1_readdatavalid, m1_readdata, grant_id, m0_waitrequest, m1_waitrequest} !== {2'b00, 23'h0, 1'b0, 32'h0, 1'b0, 2'b11}) begin
      n_bad++;
      $display("FAIL reset_mid: got busy=%b rd=%b addr=%h rdv=%b data=%h gid=%b wr=%b%b, required 0 0 0 0 0 0 11",
               busy, flsh_read, flsh_address, m1_readdatavalid, m1_readdata, grant_id, m0_waitrequest, m1_waitrequest);
    end
    cyc(); cyc();
    m0_read = 0; m1_read = 0; rst_n = 1;
    flsh_readdatavalid = 1; flsh_readdata = 32'hFEEDFACE;
    cyc();
    flsh_readdatavalid = 0;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({m1_readdatavalid, m0_readdatavalid, busy, flsh_read, m1_readdata} !== {4'b0000, 32'h0}) begin
        n_bad++;
        $display("FAIL reset_late_valid[%0d]: got rdv=%b%b busy=%b rd=%b data=%h, required 0 0 0 0 0",
                 i, m1_readdatavalid, m0_readdatavalid, busy, flsh_read, m1_readdata);
      end
      cyc();
    end
  endtask
  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_contention();
    test_timeout();
    test_coincidence();
    test_spurious();
    test_reset_mid();
    cyc(); cyc();
    n_cmp++;
    if (sb.size() !== 0) begin n_bad++; $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
